btn_event_ctrl: RTL

Multi-channel push-button front end for the clock's set/adjust keys. Synchronizes `BTN_N` raw button inputs, debounces them with one shared sample-tick prescaler, and sequences per-button event pulses: press, release, long-press and optional auto-repeat. Sits between the board pins and the mode/adjust FSMs, replacing per-button ad-hoc edge detection with one scheduled, time-qualified event source.

---
 rtl/btn_event_ctrl.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/btn_event_ctrl.sv
// btn_event_ctrl
//
// Multi-channel push-button front end. Each raw input is brought into the
// clock domain by a 2-FF synchronizer. One shared prescaler produces a sample
// tick. Each channel then debounces its input on ticks and sequences
// press / release / long-press (and optionally auto-repeat) pulses.
//
// Build option:
//   BTN_AUTO_REPEAT_EN  defined     -> LONG state emits btn_repeat every REPEAT_TICKS ticks
//                       not defined -> no repeat counter, btn_repeat tied to 0,
//                                      LONG is held until release
//
// Ports:
//   clk          single clock, rising edge
//   reset_n      asynchronous active-low reset
//   btn_raw      raw asynchronous button inputs, 1 = pressed
//   btn_level    debounced level per button
//   btn_press    1-cycle pulse on debounced 0->1
//   btn_release  1-cycle pulse on debounced 1->0
//   btn_long     1-cycle pulse when a hold reaches LONG_TICKS ticks
//   btn_repeat   1-cycle auto-repeat pulse while in LONG
//   tick         1-cycle sample-tick strobe shared by all channels
module btn_event_ctrl #(
    parameter int unsigned BTN_N        = 4,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned STABLE_TICKS = 10,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 200
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [BTN_N-1:0] btn_raw,
    output logic [BTN_N-1:0] btn_level,
    output logic [BTN_N-1:0] btn_press,
    output logic [BTN_N-1:0] btn_release,
    output logic [BTN_N-1:0] btn_long,
    output logic [BTN_N-1:0] btn_repeat,
    output logic             tick
);

    localparam int unsigned DivW  = $clog2(TICK_DIV);
    localparam int unsigned DbW   = $clog2(STABLE_TICKS + 1);
    localparam int unsigned HoldW = $clog2(LONG_TICKS + 1);

    localparam logic [DivW-1:0]  DivLast  = DivW'(TICK_DIV - 1);
    localparam logic [DivW-1:0]  DivPre   = DivW'(TICK_DIV - 2);
    localparam logic [DbW-1:0]   DbLast   = DbW'(STABLE_TICKS - 1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_TICKS - 1);
    localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_TICKS);

`ifdef BTN_AUTO_REPEAT_EN
    localparam int unsigned     RepW    = $clog2(REPEAT_TICKS + 1);
    localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        StIdle,
        StHeld,
        StLong
    } state_e;

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    logic [BTN_N-1:0] sync1_q;
    logic [BTN_N-1:0] sync2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // ------------------------------------------------------------------
    // Prescaler: tick is registered and asserted while div_q == TICK_DIV-1,
    // so it is set on the edge where the counter moves onto that value.
    // ------------------------------------------------------------------
    logic [DivW-1:0] div_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            tick  <= 1'b0;
        end else begin
            if (div_q == DivLast) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + 1'b1;
            end
            tick <= (div_q == DivPre);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel debounce + event FSM
    // ------------------------------------------------------------------
    state_e           state_q    [BTN_N];
    logic [DbW-1:0]   db_cnt_q   [BTN_N];
    logic [HoldW-1:0] hold_cnt_q [BTN_N];
`ifdef BTN_AUTO_REPEAT_EN
    logic [RepW-1:0]  rep_cnt_q  [BTN_N];
`endif

    // A disagreeing tick that would bring db_cnt up to STABLE_TICKS flips the level.
    logic [BTN_N-1:0] flip;

    always_comb begin
        flip = '0;
        for (int i = 0; i < int'(BTN_N); i++) begin
            flip[i] = (sync2_q[i] != btn_level[i]) && (db_cnt_q[i] == DbLast);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
            btn_long    <= '0;
`ifdef BTN_AUTO_REPEAT_EN
            btn_repeat  <= '0;
`endif
            for (int i = 0; i < int'(BTN_N); i++) begin
                state_q[i]    <= StIdle;
                db_cnt_q[i]   <= '0;
                hold_cnt_q[i] <= '0;
`ifdef BTN_AUTO_REPEAT_EN
                rep_cnt_q[i]  <= '0;
`endif
            end
        end else begin
            btn_press   <= '0;
            btn_release <= '0;
            btn_long    <= '0;
`ifdef BTN_AUTO_REPEAT_EN
            btn_repeat  <= '0;
`endif
            if (tick) begin
                for (int i = 0; i < int'(BTN_N); i++) begin
                    // Debounce: any agreeing tick restarts qualification.
                    if ((sync2_q[i] == btn_level[i]) || flip[i]) begin
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
                    end

                    if (flip[i]) begin
                        btn_level[i] <= ~btn_level[i];
                        if (!btn_level[i]) begin
                            state_q[i]    <= StHeld;
                            hold_cnt_q[i] <= '0;
                            btn_press[i]  <= 1'b1;
                        end else begin
                            // Release wins over any long/repeat due on this tick.
                            state_q[i]     <= StIdle;
                            btn_release[i] <= 1'b1;
                        end
                    end else if (btn_level[i]) begin
                        if (hold_cnt_q[i] != HoldMax) begin
                            hold_cnt_q[i] <= hold_cnt_q[i] + 1'b1;
                        end
                        case (state_q[i])
                            StHeld: begin
                                if (hold_cnt_q[i] == HoldLast) begin
                                    state_q[i]  <= StLong;
                                    btn_long[i] <= 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
                                    rep_cnt_q[i] <= '0;
`endif
                                end
                            end
                            StLong: begin
`ifdef BTN_AUTO_REPEAT_EN
                                if (rep_cnt_q[i] == RepLast) begin
                                    rep_cnt_q[i]  <= '0;
                                    btn_repeat[i] <= 1'b1;
                                end else begin
                                    rep_cnt_q[i] <= rep_cnt_q[i] + 1'b1;
                                end
`endif
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

`ifndef BTN_AUTO_REPEAT_EN
    assign btn_repeat = '0;
`endif

endmodule
